// File: rtl/imem_sync.sv
// imem_sync: synchronous-read instruction memory with a valid/ready fetch handshake.
// Latency: exactly one cycle from an accepted request to its response in the output register.
// Backpressure: a held response stalls new requests until rsp_ready; loader writes win over fetches.
// Optional feature: define IMEM_LOADER_EN to add the prog_* write port.
module imem_sync #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 32,
  parameter int                DEPTH      = 128,
  parameter                    INIT_FILE  = "",
  parameter logic [DATA_W-1:0] FAULT_INSN = DATA_W'(32'h00000013)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_fault,
  output logic [31:0]       fetch_cnt
`ifdef IMEM_LOADER_EN
  ,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_wdata
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_fault;
  logic [31:0]       r_fetch_cnt;

  logic              w_loader_busy;
  logic              w_accept;
  logic              w_mis;
  logic              w_oor;
  logic [IDX_W-1:0]  w_req_idx;

`ifdef IMEM_LOADER_EN
  logic [IDX_W-1:0] w_prog_idx;
  logic             w_prog_oor;
  logic             w_unused_prog_lsb;

  assign w_loader_busy     = prog_we;
  assign w_prog_idx        = prog_addr[IDX_W+1:2];
  assign w_prog_oor        = |(prog_addr >> (IDX_W + 2));
  // Byte offset within the word is meaningless for whole-word loads.
  assign w_unused_prog_lsb = ^prog_addr[1:0];

  // Loader write; out-of-range addresses are silently dropped.
  always_ff @(posedge clk) begin
    if (prog_we && !w_prog_oor) r_mem[w_prog_idx] <= prog_wdata;
  end
`else
  assign w_loader_busy = 1'b0;
`endif

  // Address decode: word index plus the two fault conditions.
  assign w_req_idx = req_addr[IDX_W+1:2];
  assign w_mis     = (req_addr[1:0] != 2'b00);
  assign w_oor     = |(req_addr >> (IDX_W + 2));

  // Ready depends only on state, consumer ready and loader activity, never on req_valid.
  assign req_ready = ((r_state == ST_EMPTY) || rsp_ready) && !w_loader_busy;
  assign w_accept  = req_valid && req_ready;

  assign rsp_valid = (r_state == ST_FULL);
  assign rsp_rdata = r_rdata;
  assign rsp_fault = r_fault;
  assign fetch_cnt = r_fetch_cnt;

  // Response-holding state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next state: fill on accept, drain when consumed without a new accept, else hold.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL: begin
        if (w_accept)       w_state_nxt = ST_FULL;
        else if (rsp_ready) w_state_nxt = ST_EMPTY;
      end
      default:              w_state_nxt = ST_EMPTY;
    endcase
  end

  // Response register and fetch counter; a faulted fetch never touches the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata     <= '0;
      r_fault     <= '0;
      r_fetch_cnt <= '0;
    end else if (w_accept) begin
      r_fault     <= {w_oor, w_mis};
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_oor || w_mis) r_rdata <= FAULT_INSN;
      else                r_rdata <= r_mem[w_req_idx];
    end
  end

endmodule

// File: tb/tb_imem_sync.sv
// Self-checking bench for imem_sync: directed fetch sequence with a response scoreboard.
// Expected words come from a bench-side memory image and address decode.
// Covers reset, back-to-back fetches, faults, stall, async reset, loader, counter wrap.
module tb_imem_sync;

  localparam int DEPTH = 128;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  f;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_fault;
  logic [31:0] fetch_cnt;
  logic        busy;
`ifdef IMEM_LOADER_EN
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_wdata;
  assign busy = prog_we;
`else
  assign busy = 1'b0;
`endif

  int          checks;
  int          errors;
  exp_t        sb[$];
  exp_t        cur;
  logic        exp_vld;
  logic [31:0] cnt_model;
  logic [31:0] mdl [DEPTH];

  imem_sync #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_fault (rsp_fault),
    .fetch_cnt (fetch_cnt)
`ifdef IMEM_LOADER_EN
    ,
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_wdata(prog_wdata)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a);
    exp_t        e;
    logic [31:0] w;
    w      = a >> 2;
    e.f[0] = (a[1:0] != 2'b00);
    e.f[1] = (w >= DEPTH);
    e.d    = (|e.f) ? 32'h00000013 : mdl[a[8:2]];
    return e;
  endfunction

  // One clock: check ready, push on accept, then check the registered response.
  task automatic tick(input string tag);
    logic acc;
    logic rdy;
    #1;
    check({tag, ".req_ready"}, 64'(req_ready), 64'((!exp_vld || rsp_ready) && !busy));
    acc = req_valid && req_ready;
    rdy = rsp_ready;
    if (acc) sb.push_back(model(req_addr));
    @(posedge clk);
    #1;
    if (acc) begin
      cnt_model = cnt_model + 32'd1;
      exp_vld   = 1'b1;
      cur       = sb.pop_front();
    end else if (rdy) begin
      exp_vld = 1'b0;
    end
    check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(exp_vld));
    check({tag, ".fetch_cnt"}, 64'(fetch_cnt), 64'(cnt_model));
    if (exp_vld) begin
      check({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'(cur.d));
      check({tag, ".rsp_fault"}, 64'(rsp_fault), 64'(cur.f));
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_vld   = 1'b0;
    cnt_model = '0;
    cur       = '0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
`ifdef IMEM_LOADER_EN
    prog_we    = 1'b0;
    prog_addr  = '0;
    prog_wdata = '0;
`endif
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    mdl[0] = 32'h00500113;
    mdl[1] = 32'h00C00193;
`ifndef IMEM_LOADER_EN
    dut.r_mem[0] = 32'h00500113;
    dut.r_mem[1] = 32'h00C00193;
`endif

    // Reset values
    #2;
    check("rst.rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst.rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("rst.rsp_fault", 64'(rsp_fault), 64'(0));
    check("rst.fetch_cnt", 64'(fetch_cnt), 64'(0));
    check("rst.req_ready", 64'(req_ready), 64'(1));
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef IMEM_LOADER_EN
    // Load the two program words through the loader port
    prog_we = 1'b1; prog_addr = 32'h0; prog_wdata = 32'h00500113;
    tick("load0");
    prog_addr = 32'h4; prog_wdata = 32'h00C00193;
    tick("load1");
    prog_we = 1'b0;
`endif

    // Back-to-back fetches of words 0 and 1
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h0;
    tick("b2b0");
    req_addr = 32'h4;
    tick("b2b1");
    req_valid = 1'b0;
    tick("drain1");

    // Faults: misaligned, out of range, both
    req_valid = 1'b1; req_addr = 32'h6;
    tick("mis");
    req_addr = 32'h200;
    tick("oor");
    req_addr = 32'h203;
    tick("both");

    // Stall: held response stays stable, new address ignored
    req_addr = 32'h4;
    tick("stall_acc");
    rsp_ready = 1'b0; req_addr = 32'h0;
    for (int i = 0; i < 3; i++) tick("stall");
    rsp_ready = 1'b1; req_valid = 1'b0;
    tick("unstall");
    tick("idle");

    // Async reset while FULL drops the pending response
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
    tick("pre_rst");
    req_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("arst.rsp_valid", 64'(rsp_valid), 64'(0));
    check("arst.fetch_cnt", 64'(fetch_cnt), 64'(0));
    check("arst.rsp_rdata", 64'(rsp_rdata), 64'(0));
    exp_vld   = 1'b0;
    cnt_model = '0;
    sb.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h4;
    tick("post_rst");
    req_valid = 1'b0;
    tick("post_rst_drain");

`ifdef IMEM_LOADER_EN
    // Loader has priority; fetch after the write sees the new word
    prog_we = 1'b1; prog_addr = 32'h8; prog_wdata = 32'hDEADBEEF;
    req_valid = 1'b1; req_addr = 32'h8;
    tick("ld_block");
    mdl[2] = 32'hDEADBEEF;
    prog_we = 1'b0;
    tick("ld_fetch");
    req_valid = 1'b0;
    tick("ld_drain");
`endif

    // Counter wrap from all-ones to zero
    force dut.r_fetch_cnt = 32'hFFFFFFFF;
    #1 release dut.r_fetch_cnt;
    cnt_model = 32'hFFFFFFFF;
    check("wrap.pre", 64'(fetch_cnt), 64'(cnt_model));
    req_valid = 1'b1; req_addr = 32'h0;
    tick("wrap");
    req_valid = 1'b0;
    tick("wrap_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
